// File: rtl/mux_arb_pkg.sv
// Shared types for the channel selector/arbiter family.
package mux_arb_pkg;

    typedef enum logic {MODE_MANUAL, MODE_RR} mode_t;
    typedef enum logic {EMPTY, FULL} occ_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority finder: returns the first requesting index at or after ptr, wrapping.
module rr_pick #(
    parameter  int NCH  = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] idx,
    output logic            any
);

    int pos;

    // Walk offsets from farthest to nearest so the closest requester after ptr wins.
    always_comb begin
        idx = ptr;
        any = |req;
        pos = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= NCH) begin
                pos = pos - NCH;
            end
            if (req[pos]) begin
                idx = SELW'(pos);
            end
        end
    end

endmodule

// File: rtl/mux_arb_rr.sv
// NCH-channel registered selector with manual and round-robin modes and a one-deep valid/ready output stage.
module mux_arb_rr
    import mux_arb_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NCH   = 4,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*WIDTH-1:0] data_in,
    output logic [NCH-1:0]       grant,
    output logic [WIDTH-1:0]     data_out,
    output logic [SELW-1:0]      ch_out,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int NPAD = 1 << SELW;

    occ_t             occ_q;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [SELW-1:0]  ch_q;
    logic [WIDTH-1:0] data_q;

    logic [SELW-1:0]  cand, rrIdx;
    logic [WIDTH-1:0] capWord;
    logic [NCH-1:0]   grantRaw;
    logic [NPAD-1:0]  reqPad;
    logic             modeRr, loadEn, hit, rrAny, doGrant;

    rr_pick #(.NCH(NCH)) uPick (
        .req (req),
        .ptr (ptr_q),
        .idx (rrIdx),
        .any (rrAny)
    );

    // Zero-padding req to a power of two makes out-of-range manual selects read as "no request".
    assign reqPad = NPAD'(req);
    assign modeRr = (mode_t'(mode) == MODE_RR);

    always_comb begin
        loadEn = (occ_q == EMPTY) || out_ready;
        if (modeRr) begin
            cand = rrIdx;
            hit  = rrAny;
        end else begin
            cand = sel;
            hit  = reqPad[sel];
        end
        doGrant  = loadEn && hit;
        grantRaw = '0;
        capWord  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cand == SELW'(i)) begin
                grantRaw[i] = doGrant;
                capWord     = data_in[i*WIDTH +: WIDTH];
            end
        end
        ptr_d = ptr_q;
        if (doGrant && modeRr) begin
            ptr_d = (cand == SELW'(NCH - 1)) ? '0 : cand + 1'b1;
        end
    end

    // The flops are already held in reset, so only the visible grant needs gating.
    assign grant = grantRaw & {NCH{reset_n}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q  <= EMPTY;
            ptr_q  <= '0;
            ch_q   <= '0;
            data_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (doGrant) begin
                data_q <= capWord;
                ch_q   <= cand;
                occ_q  <= FULL;
            end else if ((occ_q == FULL) && out_ready) begin
                occ_q <= EMPTY;
            end
        end
    end

    assign data_out  = data_q;
    assign ch_out    = ch_q;
    assign out_valid = (occ_q == FULL);

endmodule

// File: tb/tb_mux_arb_rr.sv
// Scoreboard bench for mux_arb_rr: directed vectors, grants checked at issue, words checked on consumption.
module tb_mux_arb_rr;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  req;
    logic [127:0] data_in;
    logic [3:0]  grant;
    logic [31:0] data_out;
    logic [1:0]  ch_out;
    logic        out_valid;
    logic        out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [2:0]  req3;
    logic [23:0] data_in3;
    logic [2:0]  grant3;
    logic [7:0]  data_out3;
    logic [1:0]  ch_out3;
    logic        out_valid3;
    logic        out_ready3;

    logic [31:0] word  [4] = '{32'h1111_0000, 32'h2222_0001, 32'hDEAD_BEEF, 32'h4444_0003};
    logic [7:0]  word3 [3] = '{8'hA1, 8'hB2, 8'hC3};

    exp_t sbQ[$];
    int   checks   = 0;
    int   failures = 0;

    mux_arb_rr #(.WIDTH(32), .NCH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode),
        .sel       (sel),
        .req       (req),
        .data_in   (data_in),
        .grant     (grant),
        .data_out  (data_out),
        .ch_out    (ch_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_arb_rr #(.WIDTH(8), .NCH(3)) dut3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode3),
        .sel       (sel3),
        .req       (req3),
        .data_in   (data_in3),
        .grant     (grant3),
        .data_out  (data_out3),
        .ch_out    (ch_out3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; checks grant mid-cycle and queues the word it should capture.
    task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [3:0] r,
                                 input logic rdy, input logic [3:0] expGrant, input string name);
        exp_t e;
        mode      = m;
        sel       = s;
        req       = r;
        out_ready = rdy;
        @(negedge clk);
        checkOutput(name, 64'(grant), 64'(expGrant));
        #1;
        if (expGrant != 4'b0000) begin
            e.ch = 2'd0;
            for (int i = 0; i < 4; i++) begin
                if (expGrant[i]) e.ch = 2'(i);
            end
            e.data = word[e.ch];
            sbQ.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulusNarrow(input logic m, input logic [1:0] s, input logic [2:0] r,
                                       input logic [2:0] expGrant, input string name);
        mode3      = m;
        sel3       = s;
        req3       = r;
        out_ready3 = 1'b1;
        @(negedge clk);
        checkOutput(name, 64'(grant3), 64'(expGrant));
        @(posedge clk);
        #1;
    endtask

    // Monitor: every consumed word must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sbQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_word: got ch %0d data %0h expected no word", ch_out, data_out);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("sb_data_out", 64'(data_out), 64'(e.data));
                checkOutput("sb_ch_out", 64'(ch_out), 64'(e.ch));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        data_in    = {word[3], word[2], word[1], word[0]};
        data_in3   = {word3[2], word3[1], word3[0]};
        reset_n    = 1'b1;
        mode       = 1'b1;
        sel        = 2'd0;
        req        = 4'b1111;
        out_ready  = 1'b1;
        mode3      = 1'b1;
        sel3       = 2'd0;
        req3       = 3'b111;
        out_ready3 = 1'b1;
        #2 reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_grant", 64'(grant), 64'h0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'h0);
        checkOutput("rst_data_out", 64'(data_out), 64'h0);
        checkOutput("rst_ch_out", 64'(ch_out), 64'h0);
        checkOutput("rst_grant3", 64'(grant3), 64'h0);
        checkOutput("rst_out_valid3", 64'(out_valid3), 64'h0);
        req3 = 3'b000;
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Round robin from ptr=0 with all channels requesting.
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, "rr_g0");
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, "rr_g1");
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, "rr_g2");
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, "rr_g3");
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, "rr_g0_again");

        // Manual select; sel points at a non-requesting channel next.
        applyStimulus(1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, "man_sel2");
        applyStimulus(1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, "man_sel2_noreq");
        checkOutput("man_drain_valid", 64'(out_valid), 64'h0);
        applyStimulus(1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, "man_empty_noreq");

        // Backpressure: ptr was left at 1 by the RR phase.
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, "bp_fill");
        for (int n = 0; n < 5; n++) begin
            applyStimulus(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, "bp_stall_grant");
            checkOutput("bp_stall_data", 64'(data_out), 64'(word[1]));
            checkOutput("bp_stall_valid", 64'(out_valid), 64'h1);
        end
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, "bp_resume2");
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, "bp_resume3");
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, "bp_resume0");

        // Wrap and skip: ptr=1 -> grant 2 sets ptr=3.
        applyStimulus(1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, "wrap_set_ptr3");
        applyStimulus(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, "wrap_skip_to1");
        applyStimulus(1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, "wrap_ptr2_pick3");
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, "wrap_idle");
        checkOutput("wrap_drain_valid", 64'(out_valid), 64'h0);

        // Mid-operation reset while holding ch1 with ptr=2.
        applyStimulus(1'b1, 2'd0, 4'b0010, 1'b0, 4'b0010, "mid_fill_ch1");
        checkOutput("mid_full_valid", 64'(out_valid), 64'h1);
        #2;
        reset_n   = 1'b0;
        req       = 4'b0110;
        out_ready = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 64'(out_valid), 64'h0);
        checkOutput("mid_rst_data", 64'(data_out), 64'h0);
        checkOutput("mid_rst_grant", 64'(grant), 64'h0);
        sbQ.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
        applyStimulus(1'b1, 2'd0, 4'b0110, 1'b1, 4'b0010, "mid_after_rel");
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, "mid_idle");

        // Narrow instance: NCH=3, WIDTH=8.
        applyStimulusNarrow(1'b0, 2'd3, 3'b111, 3'b000, "n3_sel3_nogrant");
        applyStimulusNarrow(1'b1, 2'd0, 3'b010, 3'b010, "n3_rr_g1");
        checkOutput("n3_data_ch1", 64'(data_out3), 64'(word3[1]));
        checkOutput("n3_ch1", 64'(ch_out3), 64'h1);
        applyStimulusNarrow(1'b1, 2'd0, 3'b011, 3'b001, "n3_ptr2_wrap");
        checkOutput("n3_data_ch0", 64'(data_out3), 64'(word3[0]));
        checkOutput("n3_ch0", 64'(ch_out3), 64'h0);
        applyStimulusNarrow(1'b1, 2'd0, 3'b100, 3'b100, "n3_rr_g2");
        applyStimulusNarrow(1'b1, 2'd0, 3'b101, 3'b001, "n3_ptr_wrapped0");
        applyStimulusNarrow(1'b1, 2'd0, 3'b000, 3'b000, "n3_idle");
        checkOutput("n3_drain_valid", 64'(out_valid3), 64'h0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("sb_leftover", 64'(sbQ.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_arb_rr.md
# mux_arb_rr

Parametrised successor of the fixed 4:1, 1-bit selector: an NCH-channel, WIDTH-bit registered selector with two modes, manual (select-driven) and round-robin arbitration over requesting channels. A one-deep valid/ready output register decouples the sources from the consumer. It sits wherever several datapath producers share one bus into a register or unit, such as ALU source or write-back sharing.

## Interface
- WIDTH, 32, data width per channel (>=1)
- NCH, 4, channel count (>=2)
- SELW, $clog2(NCH), select/index width (derived, not overridden)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- mode  in  1  0 = MODE_MANUAL, 1 = MODE_RR
- sel  in  SELW  channel index used in manual mode
- req  in  NCH  per-channel request; source holds data stable while req=1 until granted
- data_in  in  NCH*WIDTH  packed channel data, channel i at [i*WIDTH +: WIDTH]
- grant  out  NCH  one-hot, combinational; channel whose word is captured at this edge
- data_out  out  WIDTH  registered selected word
- ch_out  out  SELW  index of the channel held in data_out
- out_valid  out  1  data_out holds an unconsumed word
- out_ready  in  1  consumer accepts data_out when out_valid=1

## Operation
- One clock, clk; reset is asynchronous and active-low on reset_n.
- load_en = !out_valid || out_ready.
- Manual mode:
  - cand = sel.
  - hit = req[sel] && sel < NCH.
  - sel >= NCH never grants.
- RR mode:
  - cand = first i with req[i]=1, searching ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1 (wraps modulo NCH).
  - hit = |req.
- grant = onehot(cand) when load_en && hit, else 0. grant never has more than one bit set.
- On an edge with grant != 0: data_out <= data_in[cand], ch_out <= cand, out_valid <= 1.
  - RR mode only: ptr <= cand+1, wrapping NCH-1 -> 0.
  - Manual mode leaves ptr unchanged.
- On an edge with out_valid && out_ready && grant == 0: out_valid <= 0. data_out and ch_out hold their values.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on grant.
  - FULL -> FULL on out_ready with grant (back-to-back).
  - FULL -> EMPTY on out_ready without grant.
  - FULL stalls while out_ready=0. grant is forced to 0 and data_out is stable.
- A mode change takes effect on the same cycle, since it is combinational into cand. ptr is kept across mode changes.
- Reset values: data_out=0, ch_out=0, out_valid=0, ptr=0. grant=0 while reset_n=0.
- Reset asserted mid-transfer drops the held word. Sources still asserting req are re-arbitrated from ptr=0 after release.

## Timing
- Capture latency: the word is visible on data_out one cycle after the grant edge.
- Throughput: one word per cycle while out_ready=1 and a request is present.
- grant and cand are combinational from req/sel/mode/ptr/out_valid/out_ready. There is no combinational path from data_in to any output.
- Fairness: under continuous requests from k channels, each is granted once every k grants.

## Structure
- Package mux_arb_pkg:
  - typedef enum logic {MODE_MANUAL, MODE_RR} mode_t;
  - typedef enum logic {EMPTY, FULL} occ_t;
- Sub-module rr_pick #(NCH) (input req, input ptr, output idx, output any):
  - Rotating priority finder.
  - Reused by later arbiters.
- Top holds ptr, the output register, the occupancy state, and the grant/load logic.

## Test plan
- Reset check: reset_n=0 with req=4'b1111 -> grant=0, out_valid=0, data_out=0. Release, mode=RR, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; ch_out follows one cycle later.
- Manual mode: mode=0, sel=2, data_in ch2=32'hDEADBEEF, req=4'b0100 -> grant=4'b0100; next cycle data_out=32'hDEADBEEF, ch_out=2. Then req=4'b1011 with sel=2 -> no grant, out_valid drops after consumption.
- Backpressure: FULL with out_ready=0 for 5 cycles while req=4'b1111 -> grant=0, data_out stable. out_ready=1 -> one grant per cycle resumes from the saved ptr.
- RR wrap and skip: ptr=3, req=4'b0010 -> grant=4'b0010, then ptr=2. Next req=4'b1001 -> grant=4'b1000.
- Mid-operation reset: FULL holding ch1 with ptr=2; assert reset_n=0 between clock edges -> immediately out_valid=0, data_out=0. After release with req=4'b0110 -> first grant goes to ch1 (ptr=0).
- Parameter sweep: NCH=3, WIDTH=8, manual sel=3 with req=3'b111 -> no grant. RR from ptr=2 wraps to 0.
